// File: rtl/core_lsu.sv
// -----------------------------------------------------------------------------
// core_lsu -- load/store unit sitting between EX and MEM/WB.
//
// Takes the ALU result as the effective address, rs2 as store data and funct3
// as access size/sign. It runs a valid/ready request handshake followed, for
// loads, by a response handshake on a 64-bit data memory bus. It freezes the
// front of the pipeline while an access is outstanding.
//
// Ports
//   clk, rst_n           core clock, asynchronous active-low reset
//   mem_read_i/_write_i  current instruction is a load / store (both = load)
//   funct3_i             [1:0] size B/H/W/D, [2] zero-extend on loads
//   addr_i, wdata_i      effective address, store data
//   rsd_idx_i/_o         destination register index in / out
//   lsu_stall_o          freeze PC/IF/ID/EX and the EX/MEM register
//   misalign_o           misaligned access (dropped, no bus activity)
//   rdata_o, rdata_valid_o   extended load result, valid in DONE
//   dmem_req_*           request channel (valid/ready, we, addr, wdata, wstrb)
//   dmem_rsp_*           response channel (valid, full doubleword)
// -----------------------------------------------------------------------------
module core_lsu #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read_i,
   input  logic                  mem_write_i,
   input  logic [2:0]            funct3_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [4:0]            rsd_idx_i,
   output logic                  lsu_stall_o,
   output logic                  misalign_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rdata_valid_o,
   output logic [4:0]            rsd_idx_o,
   output logic                  dmem_req_valid_o,
   input  logic                  dmem_req_ready_i,
   output logic                  dmem_req_we_o,
   output logic [ADDR_WIDTH-1:0] dmem_req_addr_o,
   output logic [DATA_WIDTH-1:0] dmem_req_wdata_o,
   output logic [7:0]            dmem_req_wstrb_o,
   input  logic                  dmem_rsp_valid_i,
   input  logic [DATA_WIDTH-1:0] dmem_rsp_rdata_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [2:0]            r_funct3;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_we;
   logic [4:0]            r_rsd_idx;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic                  w_access;
   logic                  w_misalign;
   logic                  w_start;
   logic                  w_capture;
   logic [5:0]            w_shift;
   logic [DATA_WIDTH-1:0] w_rsp_shifted;
   logic [DATA_WIDTH-1:0] w_load_ext;
   logic [7:0]            w_wstrb;

   // ------------------------------------------------------------------
   // Alignment check on the incoming instruction (size from funct3[1:0])
   // ------------------------------------------------------------------
   assign w_access = mem_read_i | mem_write_i;

   always_comb begin
      w_misalign = 1'b0;
      unique case (funct3_i[1:0])
         2'd0: w_misalign = 1'b0;
         2'd1: w_misalign = addr_i[0];
         2'd2: w_misalign = |addr_i[1:0];
         2'd3: w_misalign = |addr_i[2:0];
      endcase
   end

   assign w_start   = (r_state == IDLE) && w_access && !w_misalign;
   assign w_capture = (r_state == WAIT) && dmem_rsp_valid_i;

   // ------------------------------------------------------------------
   // Lane handling, all driven from the latched access
   // ------------------------------------------------------------------
   assign w_shift       = {r_addr[2:0], 3'b000};
   assign w_rsp_shifted = dmem_rsp_rdata_i >> w_shift;

   always_comb begin
      w_load_ext = w_rsp_shifted;
      unique case (r_funct3[1:0])
         2'd0: w_load_ext = r_funct3[2] ? {56'd0, w_rsp_shifted[7:0]}
                                        : {{56{w_rsp_shifted[7]}}, w_rsp_shifted[7:0]};
         2'd1: w_load_ext = r_funct3[2] ? {48'd0, w_rsp_shifted[15:0]}
                                        : {{48{w_rsp_shifted[15]}}, w_rsp_shifted[15:0]};
         2'd2: w_load_ext = r_funct3[2] ? {32'd0, w_rsp_shifted[31:0]}
                                        : {{32{w_rsp_shifted[31]}}, w_rsp_shifted[31:0]};
         2'd3: w_load_ext = w_rsp_shifted;   // LD and funct3=111 alike
      endcase
   end

   always_comb begin
      w_wstrb = 8'h00;
      unique case (r_funct3[1:0])
         2'd0: w_wstrb = 8'h01 << r_addr[2:0];
         2'd1: w_wstrb = 8'h03 << r_addr[2:0];
         2'd2: w_wstrb = 8'h0F << r_addr[2:0];
         2'd3: w_wstrb = 8'hFF;
      endcase
   end

   // ------------------------------------------------------------------
   // State register and access capture
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_funct3  <= '0;
         r_wdata   <= '0;
         r_we      <= 1'b0;
         r_rsd_idx <= '0;
         r_rdata   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_start) begin
            r_addr    <= addr_i;
            r_funct3  <= funct3_i;
            r_wdata   <= wdata_i;
            r_we      <= mem_write_i & ~mem_read_i;  // read wins if both set
            r_rsd_idx <= rsd_idx_i;
         end
         if (w_capture) begin
            r_rdata <= w_load_ext;
         end
      end
   end

   // ------------------------------------------------------------------
   // Next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next     = r_state;
      lsu_stall_o      = 1'b0;
      misalign_o       = 1'b0;
      rdata_valid_o    = 1'b0;
      rsd_idx_o        = rsd_idx_i;
      dmem_req_valid_o = 1'b0;
      dmem_req_we_o    = r_we;
      dmem_req_addr_o  = {r_addr[ADDR_WIDTH-1:3], 3'b000};
      dmem_req_wdata_o = r_wdata << w_shift;
      dmem_req_wstrb_o = r_we ? w_wstrb : 8'h00;

      unique case (r_state)
         IDLE: begin
            misalign_o  = w_access & w_misalign;
            lsu_stall_o = w_start;
            if (w_start) begin
               w_state_next = REQ;
            end
         end
         REQ: begin
            lsu_stall_o      = 1'b1;
            dmem_req_valid_o = 1'b1;
            if (dmem_req_ready_i) begin
               w_state_next = r_we ? DONE : WAIT;
            end
         end
         WAIT: begin
            lsu_stall_o = 1'b1;
            if (dmem_rsp_valid_i) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            // Stall drops here so the pipeline advances exactly once.
            rdata_valid_o = ~r_we;
            rsd_idx_o     = r_rsd_idx;
            w_state_next  = IDLE;
         end
      endcase
   end

   assign rdata_o = r_rdata;

endmodule

// File: tb/tb_core_lsu.sv
module tb_core_lsu;

   logic        clk;
   logic        rst_n;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [2:0]  funct3_i;
   logic [63:0] addr_i;
   logic [63:0] wdata_i;
   logic [4:0]  rsd_idx_i;
   logic        lsu_stall_o;
   logic        misalign_o;
   logic [63:0] rdata_o;
   logic        rdata_valid_o;
   logic [4:0]  rsd_idx_o;
   logic        dmem_req_valid_o;
   logic        dmem_req_ready_i;
   logic        dmem_req_we_o;
   logic [63:0] dmem_req_addr_o;
   logic [63:0] dmem_req_wdata_o;
   logic [7:0]  dmem_req_wstrb_o;
   logic        dmem_rsp_valid_i;
   logic [63:0] dmem_rsp_rdata_i;

   int n_checks = 0;
   int n_errors = 0;

   core_lsu #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .mem_read_i       (mem_read_i),
      .mem_write_i      (mem_write_i),
      .funct3_i         (funct3_i),
      .addr_i           (addr_i),
      .wdata_i          (wdata_i),
      .rsd_idx_i        (rsd_idx_i),
      .lsu_stall_o      (lsu_stall_o),
      .misalign_o       (misalign_o),
      .rdata_o          (rdata_o),
      .rdata_valid_o    (rdata_valid_o),
      .rsd_idx_o        (rsd_idx_o),
      .dmem_req_valid_o (dmem_req_valid_o),
      .dmem_req_ready_i (dmem_req_ready_i),
      .dmem_req_we_o    (dmem_req_we_o),
      .dmem_req_addr_o  (dmem_req_addr_o),
      .dmem_req_wdata_o (dmem_req_wdata_o),
      .dmem_req_wstrb_o (dmem_req_wstrb_o),
      .dmem_rsp_valid_i (dmem_rsp_valid_i),
      .dmem_rsp_rdata_i (dmem_rsp_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever wedges.
   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled 1-2 ns after
   // the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_read_i       = 1'b0;
      mem_write_i      = 1'b0;
      funct3_i         = 3'd0;
      addr_i           = '0;
      wdata_i          = '0;
      rsd_idx_i        = '0;
      dmem_req_ready_i = 1'b0;
      dmem_rsp_valid_i = 1'b0;
      dmem_rsp_rdata_i = '0;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #12;
      chk("rst_req_valid", 64'(dmem_req_valid_o), 64'd0);
      chk("rst_rdata", rdata_o, 64'd0);
      chk("rst_rdata_valid", 64'(rdata_valid_o), 64'd0);
      chk("rst_stall", 64'(lsu_stall_o), 64'd0);
      chk("rst_req_addr", dmem_req_addr_o, 64'd0);
      $display("reset checked");
      rst_n = 1'b1;
      tick();

      // ---------------- LW 0x1004 ----------------
      mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 64'h1004; rsd_idx_i = 5'd5;
      #1;
      chk("lw_idle_stall", 64'(lsu_stall_o), 64'd1);
      chk("lw_idle_misalign", 64'(misalign_o), 64'd0);
      chk("lw_idle_req_valid", 64'(dmem_req_valid_o), 64'd0);
      tick();
      dmem_req_ready_i = 1'b1; #1;
      chk("lw_req_valid", 64'(dmem_req_valid_o), 64'd1);
      chk("lw_req_addr", dmem_req_addr_o, 64'h1000);
      chk("lw_req_wstrb", 64'(dmem_req_wstrb_o), 64'd0);
      chk("lw_req_we", 64'(dmem_req_we_o), 64'd0);
      chk("lw_req_stall", 64'(lsu_stall_o), 64'd1);
      tick();
      dmem_req_ready_i = 1'b0;
      dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = 64'h80000001_00000000; #1;
      chk("lw_wait_stall", 64'(lsu_stall_o), 64'd1);
      chk("lw_wait_req_valid", 64'(dmem_req_valid_o), 64'd0);
      tick();
      dmem_rsp_valid_i = 1'b0; dmem_rsp_rdata_i = '0; rsd_idx_i = 5'd9; #1;
      chk("lw_done_stall", 64'(lsu_stall_o), 64'd0);
      chk("lw_done_rvalid", 64'(rdata_valid_o), 64'd1);
      chk("lw_done_rdata", rdata_o, 64'hFFFFFFFF_80000001);
      chk("lw_done_rsd", 64'(rsd_idx_o), 64'd5);
      $display("LW 0x1004 rdata=0x%0h", rdata_o);
      tick();
      clear_inputs(); #1;
      chk("lw_after_rvalid", 64'(rdata_valid_o), 64'd0);
      chk("lw_after_rdata_hold", rdata_o, 64'hFFFFFFFF_80000001);
      chk("lw_after_rsd_pass", 64'(rsd_idx_o), 64'd0);

      // ---------------- LBU / LB 0x2007 ----------------
      for (int s = 0; s < 2; s++) begin
         logic [63:0] exp_b;
         exp_b = (s == 0) ? 64'h00000000_000000A5 : 64'hFFFFFFFF_FFFFFFA5;
         mem_read_i = 1'b1; funct3_i = (s == 0) ? 3'b100 : 3'b000;
         addr_i = 64'h2007; rsd_idx_i = 5'd3;
         tick();                                   // -> REQ
         dmem_req_ready_i = 1'b1; #1;
         chk("lb_req_addr", dmem_req_addr_o, 64'h2000);
         tick();                                   // -> WAIT
         dmem_req_ready_i = 1'b0;
         dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = 64'hA5000000_00000000;
         tick();                                   // -> DONE
         dmem_rsp_valid_i = 1'b0; #1;
         chk(s == 0 ? "lbu_rdata" : "lb_rdata", rdata_o, exp_b);
         chk("lb_rvalid", 64'(rdata_valid_o), 64'd1);
         $display("%s 0x2007 rdata=0x%0h", s == 0 ? "LBU" : "LB", rdata_o);
         tick();
         clear_inputs();
      end

      // ---------------- SH 0x3006, ready held low 3 cycles ----------------
      mem_write_i = 1'b1; funct3_i = 3'b001; addr_i = 64'h3006;
      wdata_i = 64'h1234; rsd_idx_i = 5'd0;
      tick();                                      // -> REQ
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("sh_req_valid", 64'(dmem_req_valid_o), 64'd1);
         chk("sh_req_we", 64'(dmem_req_we_o), 64'd1);
         chk("sh_req_addr", dmem_req_addr_o, 64'h3000);
         chk("sh_req_wdata", dmem_req_wdata_o, 64'h1234_0000_0000_0000);
         chk("sh_req_wstrb", 64'(dmem_req_wstrb_o), 64'hC0);
         chk("sh_req_stall", 64'(lsu_stall_o), 64'd1);
         dmem_req_ready_i = (c == 3);
         tick();
      end
      dmem_req_ready_i = 1'b0; #1;                 // DONE
      chk("sh_done_rvalid", 64'(rdata_valid_o), 64'd0);
      chk("sh_done_stall", 64'(lsu_stall_o), 64'd0);
      chk("sh_done_req_valid", 64'(dmem_req_valid_o), 64'd0);
      $display("SH 0x3006 completed");
      tick();
      clear_inputs();

      // ---------------- LD 0x4004 misaligned, then SD 0x4008 ----------------
      mem_read_i = 1'b1; funct3_i = 3'b011; addr_i = 64'h4004; #1;
      chk("ld_mis_flag", 64'(misalign_o), 64'd1);
      chk("ld_mis_stall", 64'(lsu_stall_o), 64'd0);
      chk("ld_mis_req_valid", 64'(dmem_req_valid_o), 64'd0);
      tick();
      chk("ld_mis_req_valid_next", 64'(dmem_req_valid_o), 64'd0);
      $display("LD 0x4004 misaligned dropped");
      clear_inputs();
      mem_write_i = 1'b1; funct3_i = 3'b011; addr_i = 64'h4008;
      wdata_i = 64'h0102030405060708; #1;
      chk("sd_misalign", 64'(misalign_o), 64'd0);
      tick();                                      // -> REQ
      dmem_req_ready_i = 1'b1; #1;
      chk("sd_req_wstrb", 64'(dmem_req_wstrb_o), 64'hFF);
      chk("sd_req_addr", dmem_req_addr_o, 64'h4008);
      chk("sd_req_wdata", dmem_req_wdata_o, 64'h0102030405060708);
      tick();                                      // -> DONE
      dmem_req_ready_i = 1'b0; #1;
      chk("sd_done_stall", 64'(lsu_stall_o), 64'd0);
      $display("SD 0x4008 completed");
      tick();
      clear_inputs();

      // ---------------- Spurious responses in IDLE and REQ ----------------
      dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = 64'hDEAD_DEAD_DEAD_DEAD;
      tick();
      chk("spur_idle_rvalid", 64'(rdata_valid_o), 64'd0);
      chk("spur_idle_rdata", rdata_o, 64'hFFFFFFFF_FFFFFFA5);
      chk("spur_idle_req_valid", 64'(dmem_req_valid_o), 64'd0);
      dmem_rsp_valid_i = 1'b0;
      mem_read_i = 1'b1; funct3_i = 3'b011; addr_i = 64'h5000; rsd_idx_i = 5'd11;
      tick();                                      // -> REQ
      dmem_rsp_valid_i = 1'b1;                      // spurious, ready low
      tick();
      chk("spur_req_still_req", 64'(dmem_req_valid_o), 64'd1);
      chk("spur_req_rdata", rdata_o, 64'hFFFFFFFF_FFFFFFA5);
      dmem_rsp_valid_i = 1'b0; dmem_req_ready_i = 1'b1;
      tick();                                      // -> WAIT
      dmem_req_ready_i = 1'b0;
      dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = 64'h0123_4567_89AB_CDEF;
      tick();                                      // -> DONE
      dmem_rsp_valid_i = 1'b0; #1;
      chk("spur_ld_rdata", rdata_o, 64'h0123_4567_89AB_CDEF);
      chk("spur_ld_rsd", 64'(rsd_idx_o), 64'd11);
      $display("LD 0x5000 after spurious rsp rdata=0x%0h", rdata_o);
      tick();
      clear_inputs();

      // ---------------- Reset during WAIT ----------------
      mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 64'h6000;
      tick();                                      // -> REQ
      dmem_req_ready_i = 1'b1;
      tick();                                      // -> WAIT
      clear_inputs(); #1;
      chk("rstw_stall_before", 64'(lsu_stall_o), 64'd1);
      #2 rst_n = 1'b0; #1;
      chk("rstw_req_valid", 64'(dmem_req_valid_o), 64'd0);
      chk("rstw_rdata", rdata_o, 64'd0);
      chk("rstw_stall", 64'(lsu_stall_o), 64'd0);
      chk("rstw_rvalid", 64'(rdata_valid_o), 64'd0);
      $display("reset during WAIT checked");
      tick();
      rst_n = 1'b1;
      tick();

      // ---------------- Back-to-back LW 0x10 then SW 0x18 ----------------
      mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 64'h10; rsd_idx_i = 5'd7;
      tick();                                      // -> REQ
      dmem_req_ready_i = 1'b1; #1;
      chk("b2b_lw_req_addr", dmem_req_addr_o, 64'h10);
      tick();                                      // -> WAIT
      dmem_req_ready_i = 1'b0;
      dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = 64'h0000_0000_7FFF_FFFF;
      tick();                                      // -> DONE
      dmem_rsp_valid_i = 1'b0; #1;
      chk("b2b_lw_done_stall", 64'(lsu_stall_o), 64'd0);
      chk("b2b_lw_rsd", 64'(rsd_idx_o), 64'd7);
      chk("b2b_lw_rdata", rdata_o, 64'h0000_0000_7FFF_FFFF);
      tick();                                      // -> IDLE, new instruction
      clear_inputs();
      mem_write_i = 1'b1; funct3_i = 3'b010; addr_i = 64'h18;
      wdata_i = 64'h0000_0000_DEAD_BEEF; rsd_idx_i = 5'd0; #1;
      chk("b2b_sw_idle_stall", 64'(lsu_stall_o), 64'd1);
      chk("b2b_sw_idle_rvalid", 64'(rdata_valid_o), 64'd0);
      tick();                                      // -> REQ
      dmem_req_ready_i = 1'b1; #1;
      chk("b2b_sw_req_addr", dmem_req_addr_o, 64'h18);
      chk("b2b_sw_req_wstrb", 64'(dmem_req_wstrb_o), 64'h0F);
      chk("b2b_sw_req_wdata", dmem_req_wdata_o, 64'h0000_0000_DEAD_BEEF);
      tick();                                      // -> DONE
      dmem_req_ready_i = 1'b0; #1;
      chk("b2b_sw_done_stall", 64'(lsu_stall_o), 64'd0);
      chk("b2b_sw_done_rvalid", 64'(rdata_valid_o), 64'd0);
      $display("back-to-back LW 0x10 / SW 0x18 completed");
      tick();
      clear_inputs(); #1;
      chk("end_idle_req_valid", 64'(dmem_req_valid_o), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
